// File: rtl/latch_sequencer.sv
// latch_sequencer: presents a data word on the bus and strobes one of N_LATCH latch enables with SETUP/LATCH/HOLD timing.
// Latency: accept at edge T -> SETUP from T+1, LATCH from T+S+1, HOLD from T+S+L+1; every output is a flop.
// Backpressure: in_ready low while busy; with LATCH_SEQ_BUF_EN defined a one-entry buffer holds one more word.
module latch_sequencer #(
  parameter int DATA_W    = 8,
  parameter int N_LATCH   = 8,
  parameter int SEL_W     = 3,
  parameter int SETUP_CYC = 1,
  parameter int LATCH_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] data_out,
  output logic [N_LATCH-1:0] latch_out,
  output logic              idle,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_LATCH, S_HOLD} state_t;

  localparam int MAX_SL  = (SETUP_CYC > LATCH_CYC) ? SETUP_CYC : LATCH_CYC;
  localparam int MAX_CYC = (MAX_SL > HOLD_CYC) ? MAX_SL : HOLD_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LATCH_LD = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic [N_LATCH-1:0]  latch_out_q, latch_out_d;
  logic                idle_q, idle_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;

`ifdef LATCH_SEQ_BUF_EN
  logic                buf_full_q, buf_full_d;
  logic [SEL_W-1:0]    buf_sel_q, buf_sel_d;
  logic [DATA_W-1:0]   buf_data_q, buf_data_d;
`endif

  logic accept;
  assign accept = in_valid && in_ready_q;

  // Select values past the last latch line still run the full timing but never strobe.
  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return 32'(s) < 32'(N_LATCH);
  endfunction

  // State register: FSM, phase counter, working word, optional buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      data_out_q  <= '0;
      latch_out_q <= '0;
      idle_q      <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
`ifdef LATCH_SEQ_BUF_EN
      buf_full_q  <= 1'b0;
      buf_sel_q   <= '0;
      buf_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      data_out_q  <= data_out_d;
      latch_out_q <= latch_out_d;
      idle_q      <= idle_d;
      done_q      <= done_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
`ifdef LATCH_SEQ_BUF_EN
      buf_full_q  <= buf_full_d;
      buf_sel_q   <= buf_sel_d;
      buf_data_q  <= buf_data_d;
`endif
    end
  end

  // Next state: walk SETUP -> LATCH -> HOLD, reloading the single counter on each phase entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
`ifdef LATCH_SEQ_BUF_EN
    buf_full_d = buf_full_q;
    buf_sel_d  = buf_sel_q;
    buf_data_d = buf_data_q;
    // A word arriving while busy parks in the buffer; the HOLD exit below may claim it directly.
    if (accept && (state_q != S_IDLE)) begin
      buf_full_d = 1'b1;
      buf_sel_d  = in_sel;
      buf_data_d = in_data;
    end
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = SETUP_LD;
          sel_d   = in_sel;
          wdata_d = in_data;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_LATCH;
          cnt_d   = LATCH_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
`ifdef LATCH_SEQ_BUF_EN
          if (buf_full_q) begin
            state_d    = S_SETUP;
            cnt_d      = SETUP_LD;
            sel_d      = buf_sel_q;
            wdata_d    = buf_data_q;
            buf_full_d = 1'b0;
          end else if (accept) begin
            // Word offered in the very last HOLD cycle goes straight to SETUP.
            state_d    = S_SETUP;
            cnt_d      = SETUP_LD;
            sel_d      = in_sel;
            wdata_d    = in_data;
            buf_full_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with the FSM.
  always_comb begin
    data_out_d  = (state_d != S_IDLE) ? wdata_d : '0;
    latch_out_d = '0;
    if ((state_d == S_LATCH) && sel_ok(sel_d)) begin
      latch_out_d = N_LATCH'(1) << sel_d;
    end
    done_d = (state_d == S_HOLD) && (cnt_d == '0);
    err_d  = accept && !sel_ok(in_sel);
`ifdef LATCH_SEQ_BUF_EN
    idle_d     = (state_d == S_IDLE) && !buf_full_d;
    in_ready_d = !buf_full_d;
`else
    idle_d     = (state_d == S_IDLE);
    in_ready_d = (state_d == S_IDLE);
`endif
  end

  assign in_ready  = in_ready_q;
  assign data_out  = data_out_q;
  assign latch_out = latch_out_q;
  assign idle      = idle_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_latch_sequencer.sv
// Bench for latch_sequencer: three instances (default, N_LATCH=6, long timing).
// Each scenario plans a cycle-by-cycle expected trace, queues it, then pops and compares per cycle.
module tb_latch_sequencer;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] latch;
    logic       done;
    logic       idle;
    logic       err;
    logic       rdy;
  } obs_t;

  localparam obs_t IDLE_OBS = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam obs_t RST_OBS  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] in_sel = '0;
  logic [7:0] in_data = '0;
  logic       a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;

  logic       a_rdy, b_rdy, c_rdy;
  logic [7:0] a_data, b_data, c_data;
  logic [7:0] a_latch, c_latch;
  logic [5:0] b_latch;
  logic       a_idle, a_done, a_err;
  logic       b_idle, b_done, b_err;
  logic       c_idle, c_done, c_err;

  obs_t obs_a, obs_b, obs_c;
  assign obs_a = {a_data, a_latch, a_done, a_idle, a_err, a_rdy};
  assign obs_b = {b_data, 2'b00, b_latch, b_done, b_idle, b_err, b_rdy};
  assign obs_c = {c_data, c_latch, c_done, c_idle, c_err, c_rdy};

  obs_t exp_q[$];
  obs_t plan[0:31];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  latch_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_vld), .in_ready(a_rdy), .in_sel(in_sel), .in_data(in_data),
    .data_out(a_data), .latch_out(a_latch), .idle(a_idle), .done(a_done), .err(a_err));

  latch_sequencer #(.N_LATCH(6)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_vld), .in_ready(b_rdy), .in_sel(in_sel), .in_data(in_data),
    .data_out(b_data), .latch_out(b_latch), .idle(b_idle), .done(b_done), .err(b_err));

  latch_sequencer #(.SETUP_CYC(3), .LATCH_CYC(4), .HOLD_CYC(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .in_ready(c_rdy), .in_sel(in_sel), .in_data(in_data),
    .data_out(c_data), .latch_out(c_latch), .idle(c_idle), .done(c_done), .err(c_err));

  task automatic clear_plan();
    for (int i = 0; i < 32; i++) plan[i] = IDLE_OBS;
  endtask

  // Expected trace of one transfer accepted at edge a (cycle k = period after edge k-1).
  task automatic overlay(input int a, input int sel, input logic [7:0] data,
                         input int s, input int l, input int h, input int nl);
    for (int k = a + 1; k <= a + s + l + h; k++) begin
      plan[k].data = data;
      plan[k].idle = 1'b0;
`ifndef LATCH_SEQ_BUF_EN
      plan[k].rdy = 1'b0;
`endif
      if (k > a + s && k <= a + s + l && sel < nl) plan[k].latch = 8'(1 << sel);
      plan[k].done = (k == a + s + l + h);
      plan[k].err  = (k == a + 1) && (sel >= nl);
    end
  endtask

  task automatic push_plan(input int n);
    for (int k = 1; k <= n; k++) exp_q.push_back(plan[k]);
  endtask

  // Present one word to the chosen instance; returns right after the accept edge.
  task automatic offer(input int which, input logic [2:0] s, input logic [7:0] d);
    @(negedge clk);
    in_sel = s; in_data = d;
    a_vld = (which == 0); b_vld = (which == 1); c_vld = (which == 2);
    @(posedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = RST_OBS;
    n_checks++;
    if (obs_a !== e) begin n_fail++; $display("FAIL reset_a got %h want %h", obs_a, e); end
    n_checks++;
    if (obs_b !== e) begin n_fail++; $display("FAIL reset_b got %h want %h", obs_b, e); end
    n_checks++;
    if (obs_c !== e) begin n_fail++; $display("FAIL reset_c got %h want %h", obs_c, e); end
    rst_n = 1'b1;
    @(negedge clk);
    e = IDLE_OBS;
    n_checks++;
    if (obs_a !== e) begin n_fail++; $display("FAIL reset_release got %h want %h", obs_a, e); end
  endtask

  task automatic test_basic();
    obs_t e;
    clear_plan(); overlay(0, 3, 8'hA5, 1, 2, 1, 8); push_plan(6);
    offer(0, 3'd3, 8'hA5);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk); a_vld = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin n_fail++; $display("FAIL basic cyc%0d got %h want %h", k, obs_a, e); end
    end
  endtask

  // Second word offered from cycle 1 with junk data until the handshake edge.
  task automatic test_back_to_back();
    obs_t e;
    bit sent = 0;
    clear_plan();
    overlay(0, 3, 8'h11, 1, 2, 1, 8);
`ifdef LATCH_SEQ_BUF_EN
    overlay(4, 0, 8'h3C, 1, 2, 1, 8);
    for (int k = 2; k <= 4; k++) plan[k].rdy = 1'b0;
`else
    overlay(5, 0, 8'h3C, 1, 2, 1, 8);
`endif
    push_plan(10);
    offer(0, 3'd3, 8'h11);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin n_fail++; $display("FAIL back_to_back cyc%0d got %h want %h", k, obs_a, e); end
      if (!sent) begin
        a_vld = 1'b1; in_sel = 3'd0;
        in_data = a_rdy ? 8'h3C : 8'(8'h40 + k);
        if (a_rdy) sent = 1;
      end else begin
        a_vld = 1'b0;
      end
    end
  endtask

  task automatic test_oob();
    obs_t e;
    int   sels[3]  = '{7, 5, 6};
    logic [7:0] dats[3] = '{8'h5A, 8'h21, 8'h0F};
    for (int t = 0; t < 3; t++) begin
      clear_plan(); overlay(0, sels[t], dats[t], 1, 2, 1, 6); push_plan(6);
      offer(1, 3'(sels[t]), dats[t]);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk); b_vld = 1'b0;
        e = exp_q.pop_front();
        n_checks++;
        if (obs_b !== e) begin n_fail++; $display("FAIL oob sel%0d cyc%0d got %h want %h", sels[t], k, obs_b, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    clear_plan(); overlay(0, 2, 8'h77, 1, 2, 1, 8);
`ifdef LATCH_SEQ_BUF_EN
    plan[2].rdy = 1'b0;
`endif
    plan[3] = RST_OBS;
    for (int k = 4; k <= 7; k++) plan[k] = IDLE_OBS;
    push_plan(7);
    offer(0, 3'd2, 8'h77);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk); a_vld = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin n_fail++; $display("FAIL reset_mid cyc%0d got %h want %h", k, obs_a, e); end
`ifdef LATCH_SEQ_BUF_EN
      if (k == 1) begin a_vld = 1'b1; in_sel = 3'd4; in_data = 8'hEE; end
`endif
      if (k == 2) rst_n = 1'b0;
      if (k == 3) rst_n = 1'b1;
    end
    clear_plan(); overlay(0, 1, 8'hC3, 1, 2, 1, 8); push_plan(5);
    offer(0, 3'd1, 8'hC3);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); a_vld = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_a !== e) begin n_fail++; $display("FAIL after_reset cyc%0d got %h want %h", k, obs_a, e); end
    end
  endtask

  task automatic test_timing();
    obs_t e;
    clear_plan(); overlay(0, 6, 8'h99, 3, 4, 2, 8); push_plan(11);
    offer(2, 3'd6, 8'h99);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); c_vld = 1'b0;
      e = exp_q.pop_front();
      n_checks++;
      if (obs_c !== e) begin n_fail++; $display("FAIL timing cyc%0d got %h want %h", k, obs_c, e); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_oob();
    test_reset_mid();
    test_timing();
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL leftover_expectations got %0d want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
